// File: rtl/fre_gate_ctrl.sv
// fre_gate_ctrl -- gate sequencer for a reciprocal (equal-precision) frequency meter.
//
// The gate opens on a rising edge of fx_in and closes on the first rising edge
// at or after gate_len ACLK cycles from the opening edge. While the gate is open
// the block counts measured edges (Nx) and ACLK cycles (Ns). Software computes
// f = Nx * F_ACLK / Ns from the published results.
//
// Ports:
//   ACLK         system clock (fx_in is already synchronous to it)
//   ARESET       synchronous, active-high reset
//   start        one-cycle pulse, begins a measurement (ignored unless IDLE)
//   abort        one-cycle pulse, cancels the measurement; results are kept
//   cont_mode    1 = re-arm automatically after each result (sampled in DONE)
//   gate_len     preset gate length in ACLK cycles (0 is treated as 1)
//   timeout_len  max ACLK cycles without an fx edge (0 disables the timeout)
//   fx_in        measured signal
//   busy         registered, high in ARM or GATE
//   done         one-cycle pulse, nx_cnt/ns_cnt/flags updated this cycle
//   timeout_err  last result ended by timeout
//   ovf_err      last result had a saturated counter
//   nx_cnt       measured edges in the gate
//   ns_cnt       ACLK cycles in the gate
//   state_dbg    current FSM state (0 IDLE, 1 ARM, 2 GATE, 3 DONE)
//
// Handshake: start/abort are single-cycle strobes with no back-pressure; done is
// a single-cycle strobe and the result registers hold until the next done.
module fre_gate_ctrl #(
  parameter int CNT_W  = 32,
  parameter int GATE_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic              abort,
  input  logic              cont_mode,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [GATE_W-1:0] timeout_len,
  input  logic              fx_in,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              ovf_err,
  output logic [CNT_W-1:0]  nx_cnt,
  output logic [CNT_W-1:0]  ns_cnt,
  output logic [1:0]        state_dbg
);

  localparam int CMP_W = (CNT_W > GATE_W) ? CNT_W : GATE_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_GATE = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic              fx_d;
  logic [GATE_W-1:0] gate_s;
  logic [GATE_W-1:0] tmo_s;
  logic [GATE_W-1:0] idle_cnt;
  logic [CNT_W-1:0]  nx_run;
  logic [CNT_W-1:0]  ns_run;

  logic              fx_edge;
  logic              tmo_hit;
  logic              gate_met;
  logic              enter_arm;
  logic [GATE_W-1:0] idle_inc;
  logic [CNT_W-1:0]  nx_inc;
  logic [CNT_W-1:0]  ns_inc;

  assign fx_edge  = fx_in & ~fx_d;
  // idle_cnt counts completed edge-free cycles; the cycle that would make it
  // equal timeout_len ends the measurement.
  assign tmo_hit  = (tmo_s != '0) && (idle_cnt >= (tmo_s - GATE_W'(1)));
  // ns_run holds (c - e_open) in the current GATE cycle.
  assign gate_met = CMP_W'(ns_run) >= CMP_W'(gate_s);
  assign idle_inc = (idle_cnt == '1) ? idle_cnt : idle_cnt + GATE_W'(1);
  assign nx_inc   = (nx_run == '1) ? nx_run : nx_run + CNT_W'(1);
  assign ns_inc   = (ns_run == '1) ? ns_run : ns_run + CNT_W'(1);
  assign enter_arm = ~abort & (((state == S_IDLE) & start) |
                               ((state == S_DONE) & cont_mode));
  assign state_dbg = state;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= S_IDLE;
      fx_d        <= 1'b0;
      gate_s      <= '0;
      tmo_s       <= '0;
      idle_cnt    <= '0;
      nx_run      <= '0;
      ns_run      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      ovf_err     <= 1'b0;
      nx_cnt      <= '0;
      ns_cnt      <= '0;
    end else begin
      fx_d <= fx_in;
      done <= 1'b0;
      if (abort) begin
        // Results and flags keep their previous values.
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state <= S_ARM;
              busy  <= 1'b1;
            end
          end
          S_ARM: begin
            if (fx_edge) begin
              state    <= S_GATE;
              nx_run   <= '0;
              ns_run   <= CNT_W'(1);
              idle_cnt <= '0;
            end else if (tmo_hit) begin
              state       <= S_DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              timeout_err <= 1'b1;
              nx_cnt      <= '0;
              ns_cnt      <= '0;
            end else begin
              idle_cnt <= idle_inc;
            end
          end
          S_GATE: begin
            if (fx_edge) begin
              if (nx_run == '1) ovf_err <= 1'b1;
              if (gate_met) begin
                // Closing edge is counted in Nx; Ns stops at this cycle.
                state  <= S_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                nx_cnt <= nx_inc;
                ns_cnt <= ns_run;
              end else begin
                nx_run   <= nx_inc;
                ns_run   <= ns_inc;
                idle_cnt <= '0;
                if (ns_run == '1) ovf_err <= 1'b1;
              end
            end else if (tmo_hit) begin
              state       <= S_DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              timeout_err <= 1'b1;
              nx_cnt      <= '0;
              ns_cnt      <= '0;
            end else begin
              idle_cnt <= idle_inc;
              ns_run   <= ns_inc;
              if (ns_run == '1) ovf_err <= 1'b1;
            end
          end
          S_DONE: begin
            // fx_d already holds the closing edge's level, so the closing edge
            // cannot reopen the gate in continuous mode.
            if (cont_mode) begin
              state <= S_ARM;
              busy  <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end

      if (enter_arm) begin
        gate_s      <= (gate_len == '0) ? GATE_W'(1) : gate_len;
        tmo_s       <= timeout_len;
        idle_cnt    <= '0;
        timeout_err <= 1'b0;
        ovf_err     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fre_gate_ctrl.sv
// Directed testbench for fre_gate_ctrl.
module tb_fre_gate_ctrl;
  localparam int CNT_W  = 32;
  localparam int GATE_W = 32;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic              start;
  logic              abort;
  logic              cont_mode;
  logic [GATE_W-1:0] gate_len;
  logic [GATE_W-1:0] timeout_len;
  logic              fx_in;
  logic              busy;
  logic              done;
  logic              timeout_err;
  logic              ovf_err;
  logic [CNT_W-1:0]  nx_cnt;
  logic [CNT_W-1:0]  ns_cnt;
  logic [1:0]        state_dbg;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int last_rise = 0;
  int fx_base   = 0;
  int fx_period = 10;
  int fx_high   = 5;
  bit fx_en     = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  fre_gate_ctrl #(.CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .start       (start),
    .abort       (abort),
    .cont_mode   (cont_mode),
    .gate_len    (gate_len),
    .timeout_len (timeout_len),
    .fx_in       (fx_in),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .ovf_err     (ovf_err),
    .nx_cnt      (nx_cnt),
    .ns_cnt      (ns_cnt),
    .state_dbg   (state_dbg)
  );

  // ---------------- driver tasks ----------------
  // One clock: outputs are sampled 1 ns after the edge, then the next fx level
  // is driven so the DUT sees it at the following edge.
  task automatic step();
    logic prev;
    @(posedge ACLK);
    #1;
    cyc++;
    prev = fx_in;
    if (fx_en) fx_in = (((cyc - fx_base) % fx_period) < fx_high);
    else       fx_in = 1'b0;
    if (fx_in && !prev) last_rise = cyc;
  endtask

  task automatic set_fx(input int period, input int high, input bit en);
    fx_period = period;
    fx_high   = high;
    fx_en     = en;
    fx_base   = cyc;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done !== 1'b0) cnt++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit seen;
    int cnt;
    int t0;
    int d1;

    ARESET = 1'b1; start = 1'b0; abort = 1'b0; cont_mode = 1'b0;
    gate_len = 100; timeout_len = 0; fx_in = 1'b0;
    repeat (3) step();
    check("rst_busy",  64'(busy),        64'd0);
    check("rst_done",  64'(done),        64'd0);
    check("rst_tmo",   64'(timeout_err), 64'd0);
    check("rst_ovf",   64'(ovf_err),     64'd0);
    check("rst_nx",    64'(nx_cnt),      64'd0);
    check("rst_ns",    64'(ns_cnt),      64'd0);
    check("rst_state", 64'(state_dbg),   64'd0);
    ARESET = 1'b0;
    step();

    // Period 10, gate 100 -> 10 / 100, done one cycle after closing edge.
    set_fx(10, 5, 1'b1);
    repeat (5) step();
    pulse_start();
    check("t1_busy", 64'(busy), 64'd1);
    wait_done(300, seen);
    check("t1_seen",    64'(seen),            64'd1);
    check("t1_nx",      64'(nx_cnt),          64'd10);
    check("t1_ns",      64'(ns_cnt),          64'd100);
    check("t1_tmo",     64'(timeout_err),     64'd0);
    check("t1_ovf",     64'(ovf_err),         64'd0);
    check("t1_latency", 64'(cyc - last_rise), 64'd1);
    step();
    check("t1_pulse", 64'(done), 64'd0);
    check("t1_idle",  64'(busy), 64'd0);

    // Abort mid-GATE: no done, previous results held, busy drops next cycle.
    pulse_start();
    repeat (40) step();
    check("ab_busy_pre", 64'(busy), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_busy",  64'(busy),      64'd0);
    check("ab_state", 64'(state_dbg), 64'd0);
    check("ab_nx",    64'(nx_cnt),    64'd10);
    check("ab_ns",    64'(ns_cnt),    64'd100);
    count_done(150, cnt);
    check("ab_nodone", 64'(cnt), 64'd0);

    // Period 7, gate 100 -> 15 / 105.
    set_fx(7, 3, 1'b1);
    repeat (10) step();
    pulse_start();
    wait_done(300, seen);
    check("t2_seen",    64'(seen),            64'd1);
    check("t2_nx",      64'(nx_cnt),          64'd15);
    check("t2_ns",      64'(ns_cnt),          64'd105);
    check("t2_latency", 64'(cyc - last_rise), 64'd1);

    // Period 10, gate 95 -> 10 / 100.
    gate_len = 95;
    set_fx(10, 5, 1'b1);
    repeat (10) step();
    pulse_start();
    wait_done(300, seen);
    check("t3_seen", 64'(seen),   64'd1);
    check("t3_nx",   64'(nx_cnt), 64'd10);
    check("t3_ns",   64'(ns_cnt), 64'd100);

    // fx held low, timeout 50 -> done 51..52 cycles after start.
    gate_len = 100;
    timeout_len = 50;
    set_fx(10, 5, 1'b0);
    repeat (5) step();
    t0 = cyc;
    pulse_start();
    wait_done(200, seen);
    check("tmo_seen", 64'(seen), 64'd1);
    check("tmo_lat",  64'((cyc - t0 >= 51) && (cyc - t0 <= 52)), 64'd1);
    check("tmo_flag", 64'(timeout_err), 64'd1);
    check("tmo_nx",   64'(nx_cnt),      64'd0);
    check("tmo_ns",   64'(ns_cnt),      64'd0);
    check("tmo_busy", 64'(busy),        64'd0);
    step();
    check("tmo_busy2", 64'(busy), 64'd0);
    timeout_len = 0;

    // Continuous mode, gate 40: done every 50 cycles, 4 / 40 each.
    gate_len = 40;
    cont_mode = 1'b1;
    set_fx(10, 5, 1'b1);
    repeat (5) step();
    pulse_start();
    wait_done(200, seen);
    check("c1_seen", 64'(seen),        64'd1);
    check("c1_nx",   64'(nx_cnt),      64'd4);
    check("c1_ns",   64'(ns_cnt),      64'd40);
    check("c1_tmo",  64'(timeout_err), 64'd0);
    d1 = cyc;
    wait_done(200, seen);
    check("c2_seen", 64'(seen),     64'd1);
    check("c2_gap",  64'(cyc - d1), 64'd50);
    check("c2_nx",   64'(nx_cnt),   64'd4);
    check("c2_ns",   64'(ns_cnt),   64'd40);
    d1 = cyc;
    repeat (20) step();
    cont_mode = 1'b0;
    wait_done(200, seen);
    check("c3_seen", 64'(seen),     64'd1);
    check("c3_gap",  64'(cyc - d1), 64'd50);
    check("c3_nx",   64'(nx_cnt),   64'd4);
    count_done(120, cnt);
    check("c_stop",      64'(cnt),  64'd0);
    check("c_stop_busy", 64'(busy), 64'd0);

    // start and abort together from IDLE: stays IDLE.
    gate_len = 100;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("sa_state", 64'(state_dbg), 64'd0);
    check("sa_busy",  64'(busy),      64'd0);
    count_done(150, cnt);
    check("sa_nodone", 64'(cnt),    64'd0);
    check("sa_nx",     64'(nx_cnt), 64'd4);

    // Extra start pulses during GATE are ignored: one done only.
    pulse_start();
    repeat (30) step();
    pulse_start();
    repeat (20) step();
    pulse_start();
    wait_done(200, seen);
    check("sg_seen", 64'(seen),   64'd1);
    check("sg_nx",   64'(nx_cnt), 64'd10);
    check("sg_ns",   64'(ns_cnt), 64'd100);
    count_done(200, cnt);
    check("sg_once", 64'(cnt), 64'd0);

    // Reset mid-measurement: reset values, no done.
    pulse_start();
    repeat (30) step();
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    check("mr_nx",    64'(nx_cnt),    64'd0);
    check("mr_ns",    64'(ns_cnt),    64'd0);
    check("mr_busy",  64'(busy),      64'd0);
    check("mr_state", 64'(state_dbg), 64'd0);
    count_done(150, cnt);
    check("mr_nodone", 64'(cnt), 64'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
